// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: arbitration states and requester IDs.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port that did not go last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_owner,
    output logic [1:0] pick
);

    assign pick[0] = req0 & (~req1 | (last_owner == REQ_DMA));
    assign pick[1] = req1 & (~req0 | (last_owner == REQ_CORE));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with burst locking and a shared single-port memory interface.
//
// state | meaning
// IDLE  | arbitrate between req0/req1 every cycle (round-robin on ties)
// BURST | owner locked; only owner beats are accepted until the burst ends
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic [LW-1:0]   len0,
    input  logic [LW-1:0]   len1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW/8-1:0] we0,
    input  logic [DW/8-1:0] we1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic          last_owner_q, last_owner_d;
    logic [1:0]    pick;
    logic [LW-1:0] gnt_len;
    logic          rvalid0_q, rvalid1_q;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner_q),
        .pick       (pick)
    );

    assign gnt_len = pick[1] ? len1 : len0;

    // remaining holds the number of burst beats still owed after the next one,
    // so the beat taken at remaining==0 is the final beat of the burst.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        remaining_d  = remaining_q;
        last_owner_d = last_owner_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        case (state_q)
            IDLE: begin
                gnt0 = pick[0];
                gnt1 = pick[1];
                if (pick[0] | pick[1]) begin
                    if (gnt_len == '0) begin
                        last_owner_d = pick[1];
                    end else begin
                        state_d     = BURST;
                        owner_d     = pick[1];
                        remaining_d = gnt_len - LW'(1);
                    end
                end
            end
            BURST: begin
                gnt0 = (owner_q == REQ_CORE) & req0;
                gnt1 = (owner_q == REQ_DMA) & req1;
                if (gnt0 | gnt1) begin
                    if (remaining_q == '0) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else begin
                        remaining_d = remaining_q - LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Grants are suppressed for the whole reset window, not just at the next edge.
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= REQ_CORE;
            remaining_q  <= '0;
            last_owner_q <= REQ_DMA;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            remaining_q  <= remaining_d;
            last_owner_q <= last_owner_d;
            rvalid0_q    <= gnt0 & ~|we0;
            rvalid1_q    <= gnt1 & ~|we1;
        end
    end

    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = gnt1 ? we1 : (gnt0 ? we0 : '0);
    assign mem_addr  = gnt1 ? addr1 : addr0;
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign rdata     = mem_rdata;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;

endmodule
